// File: rtl/cpu_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_fetch_queue_pkg
// Brief  : Shared types, opcode constants and instruction classifiers for
//          the fetch stage and its queue.
//          Exports: TAG_W, fetch_data_t {tag, instr, pc}, state_t,
//          j_imm(), is_jal(), is_redirect(), is_sleep().
// Rev    : 1.0  initial release
// ============================================================================
package cpu_fetch_queue_pkg;

   localparam int TAG_W = 8;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      instr;
      logic [31:0]      pc;
   } fetch_data_t;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_JUMP = 2'd1,
      WAIT_IRQ  = 2'd2
   } state_t;

   localparam logic [6:0]  OP_JAL     = 7'b1101111;
   localparam logic [6:0]  OP_JALR    = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
   localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
   localparam logic [31:0] INSN_WFI   = 32'h1050_0073;
   localparam logic [31:0] INSN_MRET  = 32'h3020_0073;

   // Sign-extended J-type immediate (byte offset, bit 0 always zero).
   function automatic logic [31:0] j_imm(input logic [31:0] insn);
      return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
   endfunction

   function automatic logic is_jal(input logic [31:0] insn);
      return insn[6:0] == OP_JAL;
   endfunction

   // Control transfers whose target only the backend can resolve.
   function automatic logic is_redirect(input logic [31:0] insn);
      return (insn[6:0] == OP_JALR) || (insn[6:0] == OP_BRANCH) || (insn == INSN_MRET);
   endfunction

   // Instructions after which fetch parks until an interrupt arrives.
   function automatic logic is_sleep(input logic [31:0] insn);
      return (insn == INSN_ECALL) || (insn == INSN_WFI);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module : cpu_fetch_fifo
// Brief  : Power-of-two circular FIFO with flush and a combinational head.
//          A push is accepted when not full, or when full with a same-cycle
//          pop. Flush empties the queue and discards a same-cycle push.
// Ports  : i_clock, i_reset        clock / sync active-high reset
//          i_push, i_push_data     write request and data
//          i_pop                   consume head (ignored when empty)
//          i_flush                 drop all entries
//          o_head                  head entry (undefined when empty)
//          o_count, o_full, o_empty occupancy status
// Rev    : 1.0  initial release
// ============================================================================
module cpu_fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_push_data,
   input  logic                           i_pop,
   input  logic                           i_flush,
   output logic [WIDTH-1:0]               o_head,
   output logic [$clog2(DEPTH+1)-1:0]     o_count,
   output logic                           o_full,
   output logic                           o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign o_full  = (count == CNT_W'(DEPTH));
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_head  = mem[rd_ptr];

   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (do_push && !i_flush) mem[wr_ptr] <= i_push_data;
   end

endmodule
`default_nettype wire

// File: rtl/cpu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : cpu_fetch_queue
// Brief  : Fetch stage. Walks the PC through an icache port, buffers fetched
//          words in a QUEUE_DEPTH FIFO for decode, parks on control transfers
//          (WAIT_JUMP) and sleep instructions (WAIT_IRQ), dispatches IRQs,
//          and optionally follows JAL targets locally (FOLLOW_JAL).
// Ports  : i_clock, i_reset                    clock / sync active-high reset
//          i_jump, i_jump_pc                   flush + redirect (any state)
//          i_irq_pending, i_irq_pc             interrupt request / vector
//          o_irq_dispatched, o_irq_epc         IRQ taken flag / return PC
//          o_icache_pc, o_icache_stall         icache request side
//          i_icache_ready, i_icache_rdata      icache response side
//          o_valid, i_ready, o_data            decode handshake, head entry
//          o_queue_count                       FIFO occupancy
//          o_starve_count                      saturating icache-starve cycles
// Rev    : 1.0  initial release
// ============================================================================
module cpu_fetch_queue
   import cpu_fetch_queue_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          QUEUE_DEPTH  = 4,
   parameter bit          FOLLOW_JAL   = 1'b0
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic                             i_jump,
   input  logic [31:0]                      i_jump_pc,
   input  logic                             i_irq_pending,
   input  logic [31:0]                      i_irq_pc,
   output logic                             o_irq_dispatched,
   output logic [31:0]                      o_irq_epc,
   output logic [31:0]                      o_icache_pc,
   output logic                             o_icache_stall,
   input  logic                             i_icache_ready,
   input  logic [31:0]                      i_icache_rdata,
   output logic                             o_valid,
   input  logic                             i_ready,
   output fetch_data_t                      o_data,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_queue_count,
   output logic [31:0]                      o_starve_count
);

   state_t           state;
   logic [31:0]      pc;
   logic [TAG_W-1:0] tag;
   logic [TAG_W-1:0] next_tag;
   fetch_data_t      push_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             irq_take;
   logic             enqueue;

   assign o_icache_pc    = pc;
   assign o_valid        = !fifo_empty;
   assign pop            = o_valid && i_ready;
   assign o_icache_stall = (fifo_full && !pop) || (state != FETCH);

   // An IRQ in FETCH pre-empts the fetch of the current PC; the PC becomes epc.
   assign irq_take = (state == FETCH) && i_irq_pending && !o_irq_dispatched;
   assign enqueue  = (state == FETCH) && i_icache_ready && (!fifo_full || pop)
                     && !i_jump && !irq_take;

   // The entry carries the post-increment tag, so the first fetch is tag 1.
   assign next_tag  = tag + TAG_W'(1);
   assign push_data = '{tag: next_tag, instr: i_icache_rdata, pc: pc};

   cpu_fetch_fifo #(
      .WIDTH ($bits(fetch_data_t)),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (enqueue),
      .i_push_data (push_data),
      .i_pop       (pop),
      .i_flush     (i_jump),
      .o_head      (o_data),
      .o_count     (o_queue_count),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state            <= FETCH;
         pc               <= RESET_VECTOR;
         tag              <= '0;
         o_irq_dispatched <= 1'b0;
         o_irq_epc        <= '0;
      end else if (i_jump) begin
         // Redirect wins over everything; an IRQ is re-evaluated next cycle.
         state <= FETCH;
         pc    <= i_jump_pc;
      end else begin
         case (state)
            FETCH: begin
               if (irq_take) begin
                  o_irq_dispatched <= 1'b1;
                  o_irq_epc        <= pc;
                  pc               <= i_irq_pc;
               end else begin
                  if (!i_irq_pending) o_irq_dispatched <= 1'b0;
                  if (enqueue) begin
                     tag <= next_tag;
                     if (FOLLOW_JAL && is_jal(i_icache_rdata))
                        pc <= pc + j_imm(i_icache_rdata);
                     else if (is_jal(i_icache_rdata) || is_redirect(i_icache_rdata))
                        state <= WAIT_JUMP;
                     else if (is_sleep(i_icache_rdata))
                        state <= WAIT_IRQ;
                     else
                        pc <= pc + 32'd4;
                  end
               end
            end
            WAIT_JUMP: begin
               // Only a redirect leaves this state.
            end
            WAIT_IRQ: begin
               if (i_irq_pending && !o_irq_dispatched) begin
                  o_irq_dispatched <= 1'b1;
                  o_irq_epc        <= pc + 32'd4;
                  pc               <= i_irq_pc;
                  state            <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)
         o_starve_count <= '0;
      else if ((state == FETCH) && !o_icache_stall && !i_icache_ready
               && (o_starve_count != 32'hFFFF_FFFF))
         o_starve_count <= o_starve_count + 32'd1;
   end

endmodule
`default_nettype wire
